sprite_plotter: RTL and testbench

Pixel-stream drawing engine that sits directly downstream of the game control FSM and upstream of the 160x120 VGA adapter. On each one-cycle draw command it rasterises one object: full-screen background, player ship, enemy ship, or bullet. It emits one pixel per clock as x/y/colour/plot, then reports completion so control can advance to its next draw state.

---
 rtl/sprite_plotter.sv | 170 +++++++++++++++++
 tb/tb_sprite_plotter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// Rasterises one object (background, ship, enemy or bullet) per draw command, one pixel per clock.
// Optional build macro SPRITE_CLIP_EN suppresses plot for pixels falling outside the visible screen.
module sprite_plotter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] obj_sel,
    input  logic [7:0] user_x,
    input  logic [7:0] enemy_x,
    input  logic [7:0] bullet_x,
    input  logic [6:0] bullet_y,
    input  logic       bullet_valid,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned SHIP_W   = 8;
    localparam int unsigned SHIP_H   = 4;
    localparam int unsigned SHIP_Y   = 112;
    localparam int unsigned ENEMY_Y  = 4;
    localparam logic [2:0]  BG_COLOUR    = 3'b000;
    localparam logic [2:0]  SHIP_COLOUR  = 3'b010;
    localparam logic [2:0]  ENEMY_COLOUR = 3'b100;
    localparam logic [2:0]  BULLET_COLOUR = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] ox_q, ox_d;
    logic [6:0] oy_q, oy_d;
    logic [7:0] w_q, w_d;
    logic [6:0] h_q, h_d;
    logic [7:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic [2:0] pix_colour_q, pix_colour_d;
    logic [7:0] x_d;
    logic [6:0] y_d;
    logic [2:0] colour_d;
    logic       plot_d, busy_d, done_d;
    logic       pix_visible;

    // Unclipped pixel position; the wide carry bits only matter when clipping
`ifdef SPRITE_CLIP_EN
    logic [8:0] ux;
    logic [7:0] uy;
    assign ux = {1'b0, ox_q} + 9'(col_q);
    assign uy = {1'b0, oy_q} + 8'(row_q);
    assign pix_visible = (ux < 9'(SCREEN_W)) && (uy < 8'(SCREEN_H));
`else
    logic [7:0] ux;
    logic [6:0] uy;
    assign ux = ox_q + col_q;
    assign uy = oy_q + row_q;
    assign pix_visible = 1'b1;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        w_d          = w_q;
        h_d          = h_q;
        col_d        = col_q;
        row_d        = row_q;
        pix_colour_d = pix_colour_q;
        x_d          = x;
        y_d          = y;
        colour_d     = colour;
        plot_d       = 1'b0;
        busy_d       = busy;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d  = 1'b1;
                    col_d   = 8'd0;
                    row_d   = 7'd0;
                    state_d = ST_SCAN;
                    case (obj_sel)
                        2'd0: begin
                            ox_d = 8'd0;  oy_d = 7'd0;
                            w_d  = 8'(SCREEN_W); h_d = 7'(SCREEN_H);
                            pix_colour_d = BG_COLOUR;
                        end
                        2'd1: begin
                            ox_d = user_x; oy_d = 7'(SHIP_Y);
                            w_d  = 8'(SHIP_W); h_d = 7'(SHIP_H);
                            pix_colour_d = SHIP_COLOUR;
                        end
                        2'd2: begin
                            ox_d = enemy_x; oy_d = 7'(ENEMY_Y);
                            w_d  = 8'(SHIP_W); h_d = 7'(SHIP_H);
                            pix_colour_d = ENEMY_COLOUR;
                        end
                        default: begin
                            ox_d = bullet_x; oy_d = bullet_y;
                            w_d  = 8'd1; h_d = 7'd2;
                            pix_colour_d = BULLET_COLOUR;
                            if (!bullet_valid) state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_SCAN: begin
                x_d      = ux[7:0];
                y_d      = uy[6:0];
                colour_d = pix_colour_q;
                plot_d   = pix_visible;
                if (col_q == 8'(w_q - 8'd1)) begin
                    col_d = 8'd0;
                    if (row_q == 7'(h_q - 7'd1)) begin
                        row_d   = 7'd0;
                        state_d = ST_DONE;
                    end else begin
                        row_d = 7'(row_q + 7'd1);
                    end
                end else begin
                    col_d = 8'(col_q + 8'd1);
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ox_q         <= 8'd0;
            oy_q         <= 7'd0;
            w_q          <= 8'd0;
            h_q          <= 7'd0;
            col_q        <= 8'd0;
            row_q        <= 7'd0;
            pix_colour_q <= 3'd0;
            x            <= 8'd0;
            y            <= 7'd0;
            colour       <= 3'd0;
            plot         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            w_q          <= w_d;
            h_q          <= h_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pix_colour_q <= pix_colour_d;
            x            <= x_d;
            y            <= y_d;
            colour       <= colour_d;
            plot         <= plot_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end
endmodule

// File: tb/tb_sprite_plotter.sv
// Directed self-checking bench for sprite_plotter; expectations follow SPRITE_CLIP_EN if defined.
module tb_sprite_plotter;
    logic       clk = 1'b0;
    logic       reset, start, bullet_valid;
    logic [1:0] obj_sel;
    logic [7:0] user_x, enemy_x, bullet_x;
    logic [6:0] bullet_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int passed = 0;
    int total  = 0;

    sprite_plotter dut (
        .clk(clk), .reset(reset), .start(start), .obj_sel(obj_sel),
        .user_x(user_x), .enemy_x(enemy_x), .bullet_x(bullet_x),
        .bullet_y(bullet_y), .bullet_valid(bullet_valid),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic wait_done(output int cycles, output int plots);
        cycles = 0;
        plots  = 0;
        while (done !== 1'b1 && cycles < 20000) begin
            step();
            cycles++;
            if (plot === 1'b1) plots++;
        end
    endtask

    initial begin
        int c, p, ex_x;
        logic ex_plot;
        reset = 1'b1; start = 1'b0; obj_sel = 2'd0; bullet_valid = 1'b0;
        user_x = 8'd0; enemy_x = 8'd0; bullet_x = 8'd0; bullet_y = 7'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_colour", 32'(colour), 0);

        // Background draw interrupted by reset at pixel 500
        start = 1'b1; obj_sel = 2'd0;
        step();
        start = 1'b0;
        chk("bg_busy", 32'(busy), 1);
        for (int i = 0; i <= 500; i++) step();
        chk("bg500_plot", 32'(plot), 1);
        chk("bg500_x", 32'(x), 20);
        chk("bg500_y", 32'(y), 3);
        chk("bg500_colour", 32'(colour), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_plot", 32'(plot), 0);
        chk("midrst_done", 32'(done), 0);
        step();
        chk("midrst_idle_busy", 32'(busy), 0);

        // Ship at user_x=80; ignored start pulse and user_x change mid-draw
        start = 1'b1; obj_sel = 2'd1; user_x = 8'd80;
        step();
        start = 1'b0;
        chk("ship_accept_busy", 32'(busy), 1);
        chk("ship_accept_plot", 32'(plot), 0);
        for (int i = 0; i < 32; i++) begin
            if (i == 5) begin start = 1'b1; obj_sel = 2'd3; bullet_valid = 1'b1; end
            if (i == 6) start = 1'b0;
            if (i == 10) user_x = 8'd5;
            step();
            chk("ship_plot", 32'(plot), 1);
            chk("ship_x", 32'(x), 32'(80 + i % 8));
            chk("ship_y", 32'(y), 32'(112 + i / 8));
            chk("ship_colour", 32'(colour), 2);
            chk("ship_done_low", 32'(done), 0);
        end
        step();
        chk("ship_end_plot", 32'(plot), 0);
        chk("ship_done", 32'(done), 1);
        chk("ship_hold_x", 32'(x), 87);
        step();
        chk("ship_done_clr", 32'(done), 0);
        chk("ship_busy_clr", 32'(busy), 0);
        step();
        chk("ship_no_queue", 32'(busy), 0);
        chk("ship_no_queue_plot", 32'(plot), 0);

        // Invalid bullet: no pixels, immediate done
        start = 1'b1; obj_sel = 2'd3; bullet_valid = 1'b0;
        step();
        start = 1'b0;
        chk("bnv_busy", 32'(busy), 1);
        step();
        chk("bnv_done", 32'(done), 1);
        chk("bnv_plot", 32'(plot), 0);
        step();
        chk("bnv_done_clr", 32'(done), 0);
        chk("bnv_busy_clr", 32'(busy), 0);

        // Valid bullet: two vertical pixels
        start = 1'b1; obj_sel = 2'd3; bullet_valid = 1'b1; bullet_x = 8'd7; bullet_y = 7'd50;
        step();
        start = 1'b0;
        bullet_y = 7'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bul_plot", 32'(plot), 1);
            chk("bul_x", 32'(x), 7);
            chk("bul_y", 32'(y), 32'(50 + i));
            chk("bul_colour", 32'(colour), 7);
        end
        step();
        chk("bul_done", 32'(done), 1);
        step();
        chk("bul_busy_clr", 32'(busy), 0);

        // Enemy at the right edge: clipped or wrapped depending on build
        start = 1'b1; obj_sel = 2'd2; enemy_x = 8'd156;
        step();
        start = 1'b0;
        p = 0;
        for (int i = 0; i < 32; i++) begin
            step();
`ifdef SPRITE_CLIP_EN
            ex_plot = (i % 8) < 4;
`else
            ex_plot = 1'b1;
`endif
            ex_x = (156 + i % 8) % 256;
            if (plot === 1'b1) p++;
            chk("enemy_plot", 32'(plot), 32'(ex_plot));
            if (ex_plot) begin
                chk("enemy_x", 32'(x), 32'(ex_x));
                chk("enemy_y", 32'(y), 32'(4 + i / 8));
                chk("enemy_colour", 32'(colour), 4);
            end
        end
`ifdef SPRITE_CLIP_EN
        chk("enemy_plot_count", 32'(p), 16);
`else
        chk("enemy_plot_count", 32'(p), 32);
`endif
        step();
        chk("enemy_done", 32'(done), 1);
        step();
        chk("enemy_busy_clr", 32'(busy), 0);

        // Back-to-back background draws with start held high
        start = 1'b1; obj_sel = 2'd0;
        step();
        chk("b2b_busy0", 32'(busy), 1);
        wait_done(c, p);
        chk("b2b_cycles0", 32'(c), 19201);
        chk("b2b_plots0", 32'(p), 19200);
        step();
        chk("b2b_restart_busy", 32'(busy), 1);
        chk("b2b_restart_done", 32'(done), 0);
        wait_done(c, p);
        chk("b2b_cycles1", 32'(c), 19201);
        chk("b2b_plots1", 32'(p), 19200);
        start = 1'b0;
        step();
        step();
        chk("b2b_final_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
